acc_fifo_port: RTL and testbench

- Accelerator-side responder for the router's FIFO request interface. One instance sits in front of each accelerator (FFT, FIR).
- Contains two independent synchronous FIFOs:
  - to-FIFO: the router puts data in; the accelerator drains it.
  - from-FIFO: the accelerator fills it; the router gets data out.
- Generates the empty/full status flags that the data bus controller uses to steer the bus, and services its put_req/get_req strobes.

---
 rtl/acc_fifo_port_pkg.sv | 16 +
 rtl/acc_fifo_port_if.sv | 36 +++
 rtl/acc_fifo_port_sync_fifo.sv | 68 ++++++
 rtl/acc_fifo_port.sv | 70 +++++++
 tb/tb_acc_fifo_port.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_fifo_port_pkg.sv
// Shared sizing defaults for the router FIFO port, the data bus controller
// and the accelerator wrappers.
package acc_fifo_port_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);
  localparam int NUM_FIFOS      = 2;

  // Slot of each FIFO inside the per-FIFO packed arrays of the port.
  typedef enum logic {
    FIFO_TO   = 1'b0,
    FIFO_FROM = 1'b1
  } fifo_sel_e;

endpackage

// File: rtl/acc_fifo_port_if.sv
// Router/accelerator facing signals of one accelerator FIFO port.
// master = router + accelerator side, slave = the port itself.
interface acc_fifo_port_if #(
  parameter int DATA_WIDTH = acc_fifo_port_pkg::DEF_DATA_WIDTH
);

  logic                  put_req;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  to_empty;
  logic                  to_full;
  logic                  get_req;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  from_empty;
  logic                  from_full;
  logic [DATA_WIDTH-1:0] acc_rd_data;
  logic                  acc_rd_valid;
  logic                  acc_rd_pop;
  logic [DATA_WIDTH-1:0] acc_wr_data;
  logic                  acc_wr_push;
  logic                  acc_wr_ready;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output put_req, data_in, get_req, acc_rd_pop, acc_wr_data, acc_wr_push,
    input  to_empty, to_full, data_out, from_empty, from_full,
           acc_rd_data, acc_rd_valid, acc_wr_ready, overflow_err, underflow_err
  );

  modport slave (
    input  put_req, data_in, get_req, acc_rd_pop, acc_wr_data, acc_wr_push,
    output to_empty, to_full, data_out, from_empty, from_full,
           acc_rd_data, acc_rd_valid, acc_wr_ready, overflow_err, underflow_err
  );

endinterface

// File: rtl/acc_fifo_port_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy counter and
// per-cycle overflow/underflow pulses for rejected requests.
module acc_fifo_port_sync_fifo #(
  parameter int DATA_WIDTH = acc_fifo_port_pkg::DEF_DATA_WIDTH,
  parameter int DEPTH      = acc_fifo_port_pkg::DEF_DEPTH,
  parameter int ADDR_WIDTH = acc_fifo_port_pkg::DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  ovf_o,
  output logic                  udf_o
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign ovf_o   = push_i & full_o;
  assign udf_o   = pop_i & empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
      2'b01:   cnt_d = cnt_q - (ADDR_WIDTH+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is deliberately outside reset; the counter alone defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Drive zero when empty so the router's tri-state path never sees stale data.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/acc_fifo_port.sv
// Accelerator-side FIFO responder: router->accelerator to-FIFO and
// accelerator->router from-FIFO, plus sticky overflow/underflow flags.
module acc_fifo_port
  import acc_fifo_port_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic             clk,
  input logic             reset,
  acc_fifo_port_if.slave  bus
);

  logic [NUM_FIFOS-1:0]                 push, pop, empty, full, ovf, udf;
  logic [NUM_FIFOS-1:0][DATA_WIDTH-1:0] wdata, head;
  logic                                 ovf_q, ovf_d;
  logic                                 udf_q, udf_d;

  assign push[FIFO_TO]    = bus.put_req;
  assign pop[FIFO_TO]     = bus.acc_rd_pop;
  assign wdata[FIFO_TO]   = bus.data_in;
  assign push[FIFO_FROM]  = bus.acc_wr_push;
  assign pop[FIFO_FROM]   = bus.get_req;
  assign wdata[FIFO_FROM] = bus.acc_wr_data;

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_fifo
    acc_fifo_port_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .wdata_i (wdata[g]),
      .head_o  (head[g]),
      .empty_o (empty[g]),
      .full_o  (full[g]),
      .ovf_o   (ovf[g]),
      .udf_o   (udf[g])
    );
  end

  assign ovf_d = ovf_q | (|ovf);
  assign udf_d = udf_q | (|udf);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.to_empty      = empty[FIFO_TO];
  assign bus.to_full       = full[FIFO_TO];
  assign bus.acc_rd_data   = head[FIFO_TO];
  assign bus.acc_rd_valid  = ~empty[FIFO_TO];
  assign bus.from_empty    = empty[FIFO_FROM];
  assign bus.from_full     = full[FIFO_FROM];
  assign bus.data_out      = head[FIFO_FROM];
  assign bus.acc_wr_ready  = ~full[FIFO_FROM];
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;

endmodule

// File: tb/tb_acc_fifo_port.sv
// Self-checking bench for acc_fifo_port: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_acc_fifo_port;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  logic [DW-1:0] to_q[$];
  logic [DW-1:0] from_q[$];
  bit            m_ovf, m_udf;

  acc_fifo_port_if #(.DATA_WIDTH(DW)) bus ();

  acc_fifo_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.put_req     = 1'b0;
    bus.data_in     = '0;
    bus.get_req     = 1'b0;
    bus.acc_rd_pop  = 1'b0;
    bus.acc_wr_data = '0;
    bus.acc_wr_push = 1'b0;
  endtask

  task automatic model_clear();
    to_q.delete();
    from_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Advance one clock; the model applies the FIFO rules to the inputs seen at the edge.
  task automatic tick();
    bit t_full, t_empty, f_full, f_empty;
    @(posedge clk);
    t_full  = (to_q.size() == DEPTH);
    t_empty = (to_q.size() == 0);
    f_full  = (from_q.size() == DEPTH);
    f_empty = (from_q.size() == 0);
    if ((bus.put_req && t_full) || (bus.acc_wr_push && f_full)) m_ovf = 1'b1;
    if ((bus.acc_rd_pop && t_empty) || (bus.get_req && f_empty)) m_udf = 1'b1;
    if (bus.acc_rd_pop && !t_empty) void'(to_q.pop_front());
    if (bus.put_req && !t_full) to_q.push_back(bus.data_in);
    if (bus.get_req && !f_empty) void'(from_q.pop_front());
    if (bus.acc_wr_push && !f_full) from_q.push_back(bus.acc_wr_data);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    #1 reset = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) tick();
    checks++; if (bus.to_empty !== 1'b1) begin failures++; $display("FAIL reset_to_empty got=%b want=1", bus.to_empty); end
    checks++; if (bus.from_empty !== 1'b1) begin failures++; $display("FAIL reset_from_empty got=%b want=1", bus.from_empty); end
    checks++; if ({bus.to_full, bus.from_full} !== 2'b00) begin failures++; $display("FAIL reset_full got=%b want=00", {bus.to_full, bus.from_full}); end
    checks++; if ({bus.acc_rd_valid, bus.acc_wr_ready} !== 2'b01) begin failures++; $display("FAIL reset_valid_ready got=%b want=01", {bus.acc_rd_valid, bus.acc_wr_ready}); end
    checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL reset_data_out got=%h want=0", bus.data_out); end
    checks++; if (bus.acc_rd_data !== '0) begin failures++; $display("FAIL reset_acc_rd_data got=%h want=0", bus.acc_rd_data); end
    checks++; if ({bus.overflow_err, bus.underflow_err} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b want=00", {bus.overflow_err, bus.underflow_err}); end
  endtask

  task automatic test_fill_to();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      bus.put_req = 1'b1;
      bus.data_in = DW'(i + 1);
      tick();
    end
    bus.put_req = 1'b0;
    checks++; if (bus.to_full !== 1'b1) begin failures++; $display("FAIL fill_to_full got=%b want=1", bus.to_full); end
    checks++; if (bus.overflow_err !== 1'b0) begin failures++; $display("FAIL fill_no_ovf_yet got=%b want=0", bus.overflow_err); end
    bus.put_req = 1'b1;
    bus.data_in = 32'hDEADBEEF;
    tick();
    bus.put_req = 1'b0;
    checks++; if (bus.overflow_err !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b want=1", bus.overflow_err); end
    checks++; if (bus.to_full !== 1'b1) begin failures++; $display("FAIL fill_still_full got=%b want=1", bus.to_full); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (bus.acc_rd_data !== DW'(i + 1)) begin
        failures++; $display("FAIL fill_pop_%0d got=%h want=%h", i, bus.acc_rd_data, DW'(i + 1));
      end
      bus.acc_rd_pop = 1'b1;
      tick();
    end
    bus.acc_rd_pop = 1'b0;
    checks++; if (bus.to_empty !== 1'b1) begin failures++; $display("FAIL fill_drained got=%b want=1", bus.to_empty); end
    checks++; if (bus.underflow_err !== 1'b0) begin failures++; $display("FAIL fill_no_udf got=%b want=0", bus.underflow_err); end
  endtask

  task automatic test_from_latency();
    apply_reset();
    bus.acc_wr_push = 1'b1;
    bus.acc_wr_data = 32'hA5A5A5A5;
    tick();
    bus.acc_wr_push = 1'b0;
    checks++; if (bus.from_empty !== 1'b0) begin failures++; $display("FAIL lat_from_empty got=%b want=0", bus.from_empty); end
    checks++; if (bus.data_out !== 32'hA5A5A5A5) begin failures++; $display("FAIL lat_data_out got=%h want=a5a5a5a5", bus.data_out); end
    bus.get_req = 1'b1;
    tick();
    bus.get_req = 1'b0;
    checks++; if (bus.from_empty !== 1'b1) begin failures++; $display("FAIL lat_from_empty_after_get got=%b want=1", bus.from_empty); end
    checks++; if (bus.data_out !== '0) begin failures++; $display("FAIL lat_data_out_zero got=%h want=0", bus.data_out); end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      bus.put_req = 1'b1; bus.data_in = $urandom; tick();
    end
    bus.put_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.acc_rd_pop = 1'b1; tick();
    end
    bus.acc_rd_pop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.put_req = 1'b1; bus.data_in = DW'(32'h100 + i); tick();
    end
    bus.put_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.acc_rd_data !== DW'(32'h100 + i) || bus.acc_rd_valid !== 1'b1) begin
        failures++; $display("FAIL wrap_pop_%0d got=%h/%b want=%h/1", i, bus.acc_rd_data, bus.acc_rd_valid, DW'(32'h100 + i));
      end
      bus.acc_rd_pop = 1'b1; tick();
    end
    bus.acc_rd_pop = 1'b0;
    checks++; if (bus.to_empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b want=1", bus.to_empty); end
  endtask

  task automatic test_simultaneous();
    int n;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      bus.acc_wr_push = 1'b1; bus.acc_wr_data = $urandom; tick();
    end
    checks++; if ({bus.from_full, bus.acc_wr_ready} !== 2'b10) begin failures++; $display("FAIL sim_full got=%b want=10", {bus.from_full, bus.acc_wr_ready}); end
    bus.acc_wr_data = 32'h00000BAD;
    bus.get_req     = 1'b1;
    tick();
    bus.acc_wr_push = 1'b0;
    bus.get_req     = 1'b0;
    checks++; if (bus.from_full !== 1'b0) begin failures++; $display("FAIL sim_full_pop got=%b want=0", bus.from_full); end
    checks++; if (bus.overflow_err !== 1'b1) begin failures++; $display("FAIL sim_ovf got=%b want=1", bus.overflow_err); end
    n = 0;
    while (bus.from_empty === 1'b0 && n < 2 * DEPTH) begin
      checks++;
      if (from_q.size() == 0 || bus.data_out !== from_q[0]) begin
        failures++; $display("FAIL sim_drain_%0d got=%h want=%h", n, bus.data_out, (from_q.size() != 0) ? from_q[0] : '0);
      end
      bus.get_req = 1'b1; tick(); n++;
    end
    bus.get_req = 1'b0;
    checks++; if (n !== DEPTH - 1) begin failures++; $display("FAIL sim_count got=%0d want=%0d", n, DEPTH - 1); end
    checks++; if (bus.underflow_err !== 1'b0) begin failures++; $display("FAIL sim_no_udf got=%b want=0", bus.underflow_err); end
    bus.acc_wr_push = 1'b1; bus.acc_wr_data = 32'h55; bus.get_req = 1'b1;
    tick();
    bus.acc_wr_push = 1'b0; bus.get_req = 1'b0;
    checks++; if (bus.from_empty !== 1'b0 || bus.data_out !== 32'h55) begin failures++; $display("FAIL sim_empty_both got=%b/%h want=0/55", bus.from_empty, bus.data_out); end
    checks++; if (bus.underflow_err !== 1'b1) begin failures++; $display("FAIL sim_udf got=%b want=1", bus.underflow_err); end
    bus.get_req = 1'b1; tick(); bus.get_req = 1'b0;
    checks++; if (bus.from_empty !== 1'b1) begin failures++; $display("FAIL sim_count_one got=%b want=1", bus.from_empty); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      bus.put_req = 1'b1; bus.data_in = $urandom; tick();
    end
    bus.put_req = 1'b0;
    checks++; if (bus.to_empty !== 1'b0) begin failures++; $display("FAIL areset_pre got=%b want=0", bus.to_empty); end
    #2 reset = 1'b1;
    model_clear();
    #1;
    checks++; if (bus.to_empty !== 1'b1 || bus.acc_rd_valid !== 1'b0) begin failures++; $display("FAIL areset_now got=%b/%b want=1/0", bus.to_empty, bus.acc_rd_valid); end
    checks++; if (bus.acc_rd_data !== '0) begin failures++; $display("FAIL areset_data got=%h want=0", bus.acc_rd_data); end
    #1 reset = 1'b0;
    bus.put_req = 1'b1; bus.data_in = 32'h77; tick();
    bus.put_req = 1'b0;
    checks++; if (bus.acc_rd_data !== 32'h77) begin failures++; $display("FAIL areset_first_push got=%h want=77", bus.acc_rd_data); end
    bus.acc_rd_pop = 1'b1; tick(); bus.acc_rd_pop = 1'b0;
    checks++; if (bus.to_empty !== 1'b1) begin failures++; $display("FAIL areset_single got=%b want=1", bus.to_empty); end
  endtask

  task automatic test_random();
    logic [7:0] got_f, exp_f;
    logic [DW-1:0] exp_to, exp_from;
    int bias;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      bias = 20 + 20 * ((c / 100) % 4);
      bus.put_req     = ($urandom_range(99) < 100 - bias);
      bus.data_in     = $urandom;
      bus.acc_rd_pop  = ($urandom_range(99) < bias);
      bus.acc_wr_push = ($urandom_range(99) < bias);
      bus.acc_wr_data = $urandom;
      bus.get_req     = ($urandom_range(99) < 100 - bias);
      tick();
      got_f = {bus.to_empty, bus.to_full, bus.from_empty, bus.from_full,
               bus.acc_rd_valid, bus.acc_wr_ready, bus.overflow_err, bus.underflow_err};
      exp_f = {to_q.size() == 0, to_q.size() == DEPTH, from_q.size() == 0, from_q.size() == DEPTH,
               to_q.size() != 0, from_q.size() != DEPTH, m_ovf, m_udf};
      exp_to   = (to_q.size() != 0) ? to_q[0] : '0;
      exp_from = (from_q.size() != 0) ? from_q[0] : '0;
      checks++; if (got_f !== exp_f) begin failures++; $display("FAIL rand_flags_c%0d got=%b want=%b", c, got_f, exp_f); end
      checks++; if (bus.acc_rd_data !== exp_to) begin failures++; $display("FAIL rand_acc_rd_data_c%0d got=%h want=%h", c, bus.acc_rd_data, exp_to); end
      checks++; if (bus.data_out !== exp_from) begin failures++; $display("FAIL rand_data_out_c%0d got=%h want=%h", c, bus.data_out, exp_from); end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    test_reset();
    test_fill_to();
    test_from_latency();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
